// File: rtl/tdm_demux_8.sv
// Frame-based 1-to-8 TDM demultiplexer: beats are steered into slot shadow
// registers by a 3-bit slot counter and a whole frame is published on slot 7.
module tdm_demux_8 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    input  logic             sync,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7,
    output logic [WIDTH-1:0] o8,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             frame_done,
    output logic             sync_err
);

    logic [2:0]       r_slot;
    logic [WIDTH-1:0] r_sh [0:6];
    logic [WIDTH-1:0] r_o  [0:7];
    logic             r_frame_done;
    logic             r_sync_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot       <= 3'd0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            for (int k = 0; k < 7; k++) r_sh[k] <= '0;
            for (int k = 0; k < 8; k++) r_o[k]  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            if (valid) begin
                if (sync) begin
                    // A sync beat always restarts the frame; mid-frame data is dropped.
                    r_sh[0]    <= d;
                    r_slot     <= 3'd1;
                    r_sync_err <= (r_slot != 3'd0);
                end else if (r_slot == 3'd7) begin
                    for (int k = 0; k < 7; k++) r_o[k] <= r_sh[k];
                    r_o[7]       <= d;
                    r_slot       <= 3'd0;
                    r_frame_done <= 1'b1;
                end else begin
                    for (int k = 0; k < 7; k++) begin
                        if (r_slot == 3'(k)) r_sh[k] <= d;
                    end
                    r_slot <= r_slot + 3'd1;
                end
            end
        end
    end

    assign o1 = r_o[0];
    assign o2 = r_o[1];
    assign o3 = r_o[2];
    assign o4 = r_o[3];
    assign o5 = r_o[4];
    assign o6 = r_o[5];
    assign o7 = r_o[6];
    assign o8 = r_o[7];

    // s0 is the MSB of the slot index.
    assign s0 = r_slot[2];
    assign s1 = r_slot[1];
    assign s2 = r_slot[0];

    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

endmodule
